// File: rtl/pedagio_sensor_front.sv
// pedagio_sensor_front
//   Lane sensor front-end for the toll accumulator. Conditions the raw loop,
//   treadle and scale inputs, counts axles and tracks peak weight while a
//   vehicle sits on the loop, then reports an encoded EIXOS/PESO pair with a
//   READY pulse once the vehicle has left.
// Ports
//   CLOCK_50   in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   LOOP_RAW   in   presence loop, async + bouncing (1 = vehicle present)
//   AXLE_RAW   in   treadle, async + bouncing (1 = wheel on treadle)
//   WEIGHT_IN  in   [3:0] scale reading in tonnes, async slow bus
//   EIXOS      out  [1:0] axle code 00=2, 01=3, 10=4, 11=5+
//   PESO       out  [3:0] peak weight of last reported vehicle
//   READY      out  high for READY_CYCLES per valid vehicle
//   FAULT      out  one-cycle pulse on a rejected vehicle
//   BUSY       out  high whenever the FSM is not idle

// Two-flop synchronizer followed by a counting debouncer. The count tracks
// consecutive synchronized samples that disagree with the current debounced
// level; a single agreeing sample restarts it.
module pedagio_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1_q, sync2_q, deb_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign deb_o = deb_q;
endmodule

module pedagio_sensor_front #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned READY_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       LOOP_RAW,
  input  logic       AXLE_RAW,
  input  logic [3:0] WEIGHT_IN,
  output logic [1:0] EIXOS,
  output logic [3:0] PESO,
  output logic       READY,
  output logic       FAULT,
  output logic       BUSY
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = $clog2(READY_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_REPORT, S_WAIT_CLEAR} state_t;

  // Conditioned inputs: index 0 = loop, 1 = axle
  logic [1:0] raw, deb;
  assign raw = {AXLE_RAW, LOOP_RAW};

  for (genvar g = 0; g < 2; g++) begin : g_db
    pedagio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i (CLOCK_50),
      .rst_i (RESET),
      .raw_i (raw[g]),
      .deb_o (deb[g])
    );
  end

  logic loop_deb, axle_deb;
  assign loop_deb = deb[0];
  assign axle_deb = deb[1];

  state_t        state_q, state_d;
  logic          axle_prev_q;
  logic [3:0]    wgt_q;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    peak_q, peak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    eixos_q, eixos_d;
  logic [3:0]    peso_q, peso_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          busy_q;

  logic       axle_edge;
  logic [2:0] cnt_inc, cnt_cap;
  logic [3:0] peak_max;

  assign axle_edge = axle_deb & ~axle_prev_q;
  // An axle edge on the falling-loop cycle must be counted before evaluation
  assign cnt_inc   = (axle_edge && cnt_q != 3'd7) ? cnt_q + 3'd1 : cnt_q;
  assign cnt_cap   = (cnt_inc > 3'd5) ? 3'd5 : cnt_inc;
  assign peak_max  = (wgt_q > peak_q) ? wgt_q : peak_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    timer_d = timer_q;
    rcnt_d  = rcnt_q;
    eixos_d = eixos_q;
    peso_d  = peso_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (loop_deb) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          peak_d  = '0;
          timer_d = '0;
        end
      end
      S_MEASURE: begin
        cnt_d   = cnt_inc;
        peak_d  = peak_max;
        timer_d = timer_q + TW'(1);
        if (!loop_deb) begin
          if (cnt_inc >= 3'd2) begin
            state_d = S_REPORT;
            eixos_d = 2'(cnt_cap - 3'd2);
            peso_d  = peak_max;
            rcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
            fault_d = 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_WAIT_CLEAR;
          fault_d = 1'b1;
        end
      end
      S_REPORT: begin
        // READY rises one cycle after entry so EIXOS/PESO settle first;
        // the final cycle drops READY while returning to IDLE.
        if (rcnt_q == RW'(READY_CYCLES)) begin
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
          rcnt_d  = rcnt_q + RW'(1);
        end
      end
      S_WAIT_CLEAR: begin
        if (!loop_deb) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      axle_prev_q <= 1'b0;
      wgt_q       <= '0;
      cnt_q       <= '0;
      peak_q      <= '0;
      timer_q     <= '0;
      rcnt_q      <= '0;
      eixos_q     <= '0;
      peso_q      <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      axle_prev_q <= axle_deb;
      wgt_q       <= WEIGHT_IN;
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      timer_q     <= timer_d;
      rcnt_q      <= rcnt_d;
      eixos_q     <= eixos_d;
      peso_q      <= peso_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign EIXOS = eixos_q;
  assign PESO  = peso_q;
  assign READY = ready_q;
  assign FAULT = fault_q;
  assign BUSY  = busy_q;
endmodule

// File: tb/tb_pedagio_sensor_front.sv
module tb_pedagio_sensor_front;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       loop_raw = 1'b0;
  logic       axle_raw = 1'b0;
  logic [3:0] weight = 4'd0;

  logic [1:0] eixos_a, eixos_b;
  logic [3:0] peso_a, peso_b;
  logic       ready_a, ready_b, fault_a, fault_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pedagio_sensor_front #(.DEBOUNCE_CYCLES(4), .READY_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
    .CLOCK_50(clk), .RESET(rst), .LOOP_RAW(loop_raw), .AXLE_RAW(axle_raw), .WEIGHT_IN(weight),
    .EIXOS(eixos_a), .PESO(peso_a), .READY(ready_a), .FAULT(fault_a), .BUSY(busy_a));

  pedagio_sensor_front #(.DEBOUNCE_CYCLES(4), .READY_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_to (
    .CLOCK_50(clk), .RESET(rst), .LOOP_RAW(loop_raw), .AXLE_RAW(axle_raw), .WEIGHT_IN(weight),
    .EIXOS(eixos_b), .PESO(peso_b), .READY(ready_b), .FAULT(fault_b), .BUSY(busy_b));

  // Running event totals, sampled on the falling edge
  int   rises_a = 0, rhigh_a = 0, fhigh_a = 0;
  int   rises_b = 0, fhigh_b = 0, bcyc_b = 0, fault_at_b = -1;
  logic rprev_a = 1'b0, rprev_b = 1'b0, bprev_b = 1'b0;

  always @(negedge clk) begin
    if (ready_a && !rprev_a) rises_a++;
    if (ready_a) rhigh_a++;
    if (fault_a) fhigh_a++;
    rprev_a = ready_a;
    if (ready_b && !rprev_b) rises_b++;
    if (fault_b) fhigh_b++;
    rprev_b = ready_b;
    if (busy_b) bcyc_b = bprev_b ? bcyc_b + 1 : 0;
    if (fault_b) fault_at_b = bcyc_b;
    bprev_b = busy_b;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic axle(input int hi, input int lo);
    axle_raw = 1'b1; tick(hi);
    axle_raw = 1'b0; tick(lo);
  endtask

  // Whole vehicle: loop up, n clean axles at weight w, loop down, let it report
  task automatic vehicle(input int n, input logic [3:0] w);
    weight = w;
    loop_raw = 1'b1; tick(10);
    for (int i = 0; i < n; i++) axle(10, 10);
    loop_raw = 1'b0; tick(25);
  endtask

  task automatic test_reset;
    rst = 1'b1; tick(3);
    checks++; if ({eixos_a, peso_a, ready_a, fault_a, busy_a} !== 9'd0) begin
      errors++; $display("FAIL reset_a outputs=%b required=0", {eixos_a, peso_a, ready_a, fault_a, busy_a}); end
    checks++; if ({eixos_b, peso_b, ready_b, fault_b, busy_b} !== 9'd0) begin
      errors++; $display("FAIL reset_b outputs=%b required=0", {eixos_b, peso_b, ready_b, fault_b, busy_b}); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_two_axle;
    int r0, h0, f0;
    r0 = rises_a; h0 = rhigh_a; f0 = fhigh_a;
    vehicle(2, 4'd5);
    checks++; if (eixos_a !== 2'b00) begin errors++; $display("FAIL two_eixos got=%b want=00", eixos_a); end
    checks++; if (peso_a !== 4'd5) begin errors++; $display("FAIL two_peso got=%0d want=5", peso_a); end
    checks++; if (rhigh_a - h0 !== 4) begin errors++; $display("FAIL two_ready_len got=%0d want=4", rhigh_a - h0); end
    checks++; if (rises_a - r0 !== 1) begin errors++; $display("FAIL two_ready_rises got=%0d want=1", rises_a - r0); end
    checks++; if (fhigh_a - f0 !== 0) begin errors++; $display("FAIL two_fault got=%0d want=0", fhigh_a - f0); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL two_busy_after got=%b want=0", busy_a); end
  endtask

  task automatic test_glitch;
    int r0, h0;
    r0 = rises_a; h0 = rhigh_a;
    loop_raw = 1'b1; tick(10);
    for (int i = 0; i < 3; i++) begin
      weight = (i == 0) ? 4'd8 : (i == 1) ? 4'd12 : 4'd9;
      for (int g = 0; g < 3; g++) axle(3, 3);
      axle(10, 10);
    end
    loop_raw = 1'b0; tick(25);
    checks++; if (eixos_a !== 2'b01) begin errors++; $display("FAIL glitch_eixos got=%b want=01", eixos_a); end
    checks++; if (peso_a !== 4'd12) begin errors++; $display("FAIL glitch_peso got=%0d want=12", peso_a); end
    checks++; if (rises_a - r0 !== 1) begin errors++; $display("FAIL glitch_rises got=%0d want=1", rises_a - r0); end
    checks++; if (rhigh_a - h0 !== 4) begin errors++; $display("FAIL glitch_ready_len got=%0d want=4", rhigh_a - h0); end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rises_a;
    vehicle(6, 4'd15);
    checks++; if (eixos_a !== 2'b11) begin errors++; $display("FAIL six_eixos got=%b want=11", eixos_a); end
    checks++; if (peso_a !== 4'd15) begin errors++; $display("FAIL six_peso got=%0d want=15", peso_a); end
    vehicle(2, 4'd3);
    checks++; if (eixos_a !== 2'b00) begin errors++; $display("FAIL b2b_eixos got=%b want=00", eixos_a); end
    checks++; if (peso_a !== 4'd3) begin errors++; $display("FAIL b2b_peso got=%0d want=3", peso_a); end
    checks++; if (rises_a - r0 !== 2) begin errors++; $display("FAIL b2b_rises got=%0d want=2", rises_a - r0); end
  endtask

  task automatic test_fault_one_axle;
    int r0, f0;
    r0 = rises_a; f0 = fhigh_a;
    vehicle(1, 4'd7);
    checks++; if (fhigh_a - f0 !== 1) begin errors++; $display("FAIL onefault_len got=%0d want=1", fhigh_a - f0); end
    checks++; if (rises_a - r0 !== 0) begin errors++; $display("FAIL onefault_ready got=%0d want=0", rises_a - r0); end
    checks++; if (eixos_a !== 2'b00) begin errors++; $display("FAIL onefault_eixos got=%b want=00", eixos_a); end
    checks++; if (peso_a !== 4'd3) begin errors++; $display("FAIL onefault_peso got=%0d want=3", peso_a); end
  endtask

  task automatic test_timeout;
    int r0, f0;
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    r0 = rises_b; f0 = fhigh_b; fault_at_b = -1;
    loop_raw = 1'b1; tick(100);
    checks++; if (fault_at_b !== 64) begin errors++; $display("FAIL timeout_cycle got=%0d want=64", fault_at_b); end
    checks++; if (fhigh_b - f0 !== 1) begin errors++; $display("FAIL timeout_fault_len got=%0d want=1", fhigh_b - f0); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL timeout_busy_held got=%b want=1", busy_b); end
    loop_raw = 1'b0; tick(15);
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL timeout_busy_clear got=%b want=0", busy_b); end
    checks++; if (rises_b - r0 !== 0) begin errors++; $display("FAIL timeout_ready got=%0d want=0", rises_b - r0); end
    checks++; if (fhigh_b - f0 !== 1) begin errors++; $display("FAIL timeout_fault_total got=%0d want=1", fhigh_b - f0); end
  endtask

  task automatic test_reset_mid_measure;
    int r0, f0;
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    vehicle(3, 4'd9);
    checks++; if ({eixos_a, peso_a} !== {2'b01, 4'd9}) begin errors++; $display("FAIL pre_reset_vehicle got=%b want=011001", {eixos_a, peso_a}); end
    weight = 4'd11;
    loop_raw = 1'b1; tick(10);
    axle(10, 10); axle(10, 10);
    r0 = rises_a; f0 = fhigh_a;
    rst = 1'b1; tick(1);
    checks++; if ({eixos_a, peso_a, ready_a, fault_a, busy_a} !== 9'd0) begin
      errors++; $display("FAIL midreset_outputs got=%b want=0", {eixos_a, peso_a, ready_a, fault_a, busy_a}); end
    loop_raw = 1'b0; tick(2); rst = 1'b0; tick(15);
    checks++; if (rises_a - r0 !== 0) begin errors++; $display("FAIL midreset_ready got=%0d want=0", rises_a - r0); end
    checks++; if (fhigh_a - f0 !== 0) begin errors++; $display("FAIL midreset_fault got=%0d want=0", fhigh_a - f0); end
    vehicle(4, 4'd6);
    checks++; if (eixos_a !== 2'b10) begin errors++; $display("FAIL four_eixos got=%b want=10", eixos_a); end
    checks++; if (peso_a !== 4'd6) begin errors++; $display("FAIL four_peso got=%0d want=6", peso_a); end
    checks++; if (rises_a - r0 !== 1) begin errors++; $display("FAIL four_rises got=%0d want=1", rises_a - r0); end
  endtask

  initial begin
    test_reset;
    test_two_axle;
    test_glitch;
    test_back_to_back;
    test_fault_one_axle;
    test_timeout;
    test_reset_mid_measure;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
